alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one registered 8-bit ALU (data_1, data_2, opcode, alu_out, one-cycle latency) among NUM_REQ requesters using round-robin arbitration.
- Accepts one request at a time via valid/ready handshake, sequences it through the ALU, and returns the result tagged with the requester ID on a response channel with backpressure.
- Sits between requester agents and the ALU instance. The scheduler is the only driver of the ALU inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ALU_LATENCY, 1, clock cycles from operands driven into the ALU to alu_out valid (1..4).
- ID_W, 2, width of rsp_id. Must be at least clog2(NUM_REQ).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept (grant). At most one bit is set.
- req_opcode  input  3*NUM_REQ  packed opcodes; slice i is [3i+2:3i]. Encoding: RST=0, MOV=1, NOT=2, ADD=3, AND=4, XOR=5, LSH=6, RSH=7.
- req_a  input  8*NUM_REQ  packed operand A per requester.
- req_b  input  8*NUM_REQ  packed operand B per requester.
- alu_data_1  output  8  to ALU data_1.
- alu_data_2  output  8  to ALU data_2.
- alu_opcode  output  3  to ALU opcode.
- alu_out  input  8  from ALU.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that issued the operation.
- rsp_data  output  8  captured ALU result.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE; all outputs 0.
  - Operand, opcode, id and result registers 0.
  - Round-robin last-grant pointer = NUM_REQ-1, so requester 0 has top priority after reset.
  - An in-flight operation is discarded with no response.
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - req_ready is combinational. It is one-hot for the first i with req_valid[i], searching from (ptr+1) mod NUM_REQ upward with wrap. All zeros if no requester is valid.
  - On a handshake edge (req_valid[i] and req_ready[i]):
    - latch opcode/a/b/id of requester i;
    - ptr <= i;
    - go to EXEC.
- EXEC:
  - alu_data_1/alu_data_2/alu_opcode driven from the latched registers. They are registered outputs and hold their values through WAIT.
  - Latency counter loaded with ALU_LATENCY-1.
  - Next state is WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0: rsp_data <= alu_out, rsp_id <= latched id, rsp_valid <= 1, go to RESP.
  - With ALU_LATENCY=1, WAIT lasts exactly one cycle.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - On that edge rsp_valid <= 0 and state goes to IDLE.
  - No new request is accepted in the RESP cycle.
- Outside EXEC/WAIT, ALU inputs are 0 (opcode RST).
- Latency: with rsp_ready held high, rsp_valid rises ALU_LATENCY+1 edges after the accepting edge. Minimum issue interval is ALU_LATENCY+3 cycles.
- req_ready is 0 in every state other than IDLE.
- A requester may drop req_valid before it is granted; no grant is issued for it.
- Simultaneous requests: only one grant per IDLE cycle, chosen by the round-robin rule. The winner becomes the lowest priority for the next arbitration.
- Pointer wrap: after granting NUM_REQ-1, the search starts at 0.
- req_* inputs are sampled only on the handshake edge. Changes afterwards do not affect the in-flight operation.
- rsp_data width is 8 bits. ADD overflow is truncated by the ALU and passed through unchanged.

Test Plan:
- Reset then idle: rst_n=0 at t=0, released after 2 edges, all req_valid=0 → req_ready=0, rsp_valid=0, busy=0, alu_opcode=0.
- Single ADD: requester 2 drives opcode=3, a=8'hF0, b=8'h20, rsp_ready=1 → req_ready=4'b0100 for one cycle; alu_opcode=3 in EXEC; rsp_valid=1, rsp_id=2, rsp_data=8'h10 two edges after accept.
- Round-robin fairness: all four requesters hold valid with distinct ops (MOV a=11, NOT a=0F, XOR 55^FF, LSH a=3C), rsp_ready=1 → grants in order 0,1,2,3,0. Results 8'h11, 8'hF0, 8'hAA, 8'hC0, tagged with ids 0,1,2,3.
- Backpressure: RSH a=8'hA5 from requester 1, rsp_ready=0 for 5 cycles then 1 → rsp_valid, rsp_id=1, rsp_data=8'h0A stable for 6 cycles. req_ready stays 0 throughout even with other requests pending.
- Reset mid-operation: assert rst_n=0 during WAIT → outputs immediately 0, no response emitted. After release, a pending request from requester 3 is granted only after requester 0 if both are valid (ptr reset to NUM_REQ-1).
- Latency parameter: ALU_LATENCY=3 with a behavioural 3-cycle ALU model, AND 8'hCC&8'h0F → rsp_data=8'h0C, rsp_valid rises 4 edges after accept.

Source files
------------

// File: rtl/alu_rr_scheduler_if.sv
// Request/response channel bundle for alu_rr_scheduler.
// master: requester side (drives requests, consumes responses).
// slave:  scheduler side (grants requests, produces responses).
interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [3*NUM_REQ-1:0] req_opcode;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_data;

    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one registered 8-bit ALU among NUM_REQ
// requesters. One operation in flight at a time; the result is returned
// tagged with the requester index on a backpressured response channel.
module alu_rr_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 1,
    parameter int ID_W        = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_rr_scheduler_if.slave   bus,
    output logic [7:0]          alu_data_1,
    output logic [7:0]          alu_data_2,
    output logic [2:0]          alu_opcode,
    input  logic [7:0]          alu_out,
    output logic                busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   lat_cnt;
    logic [ID_W-1:0]    lat_id;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [2:0]         sel_opcode;
    logic [7:0]         sel_a;
    logic [7:0]         sel_b;
    int unsigned        cand;

    // Round-robin search starting just after the last winner, idle only
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        if (state == IDLE && rst_n) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = (32'(ptr) + k) % 32'(NUM_REQ);
                if (grant == '0 && bus.req_valid[cand[PTR_W-1:0]]) begin
                    grant[cand[PTR_W-1:0]] = 1'b1;
                    grant_idx              = cand[PTR_W-1:0];
                end
            end
        end
    end

    // Operand/opcode mux for the requester currently being granted
    always_comb begin
        sel_opcode = '0;
        sel_a      = '0;
        sel_b      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_opcode = bus.req_opcode[3*i +: 3];
                sel_a      = bus.req_a[8*i +: 8];
                sel_b      = bus.req_b[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = grant;

    // Scheduler FSM; ALU inputs, response and busy are all registered here.
    // The ALU input registers double as the operand latch: loading them on the
    // accept edge makes them visible throughout EXEC, so a registered ALU has
    // its result ready when WAIT samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= PTR_INIT;
            lat_cnt      <= '0;
            lat_id       <= '0;
            alu_data_1   <= '0;
            alu_data_2   <= '0;
            alu_opcode   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id   <= '0;
            bus.rsp_data <= '0;
            busy         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant != '0) begin
                        alu_opcode <= sel_opcode;
                        alu_data_1 <= sel_a;
                        alu_data_2 <= sel_b;
                        lat_id     <= ID_W'(grant_idx);
                        ptr        <= grant_idx;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    lat_cnt <= CNT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        bus.rsp_data  <= alu_out;
                        bus.rsp_id    <= lat_id;
                        bus.rsp_valid <= 1'b1;
                        alu_data_1    <= '0;
                        alu_data_2    <= '0;
                        alu_opcode    <= '0;
                        state         <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // At most one grant, and never while an operation is in flight
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));
    a_grant_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> (bus.req_ready == '0));
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed scenarios plus random
// traffic, checked by a scoreboard fed from a round-robin reference model.
module tb_alu_rr_scheduler;
    localparam int N = 4;
    localparam logic [2:0] OP_RST = 3'd0, OP_MOV = 3'd1, OP_NOT = 3'd2, OP_ADD = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4, OP_XOR = 3'd5, OP_LSH = 3'd6, OP_RSH = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rr_scheduler_if #(.NUM_REQ(N), .ID_W(2)) bus ();
    alu_rr_scheduler_if #(.NUM_REQ(N), .ID_W(2)) bus3 ();

    logic [7:0] alu_d1, alu_d2, alu_out;
    logic [2:0] alu_op;
    logic       busy;
    logic [7:0] alu3_d1, alu3_d2, alu3_out;
    logic [2:0] alu3_op;
    logic       busy3;
    logic [7:0] pipe3 [3];

    alu_rr_scheduler #(.NUM_REQ(N), .ALU_LATENCY(1), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_data_1(alu_d1), .alu_data_2(alu_d2), .alu_opcode(alu_op),
        .alu_out(alu_out), .busy(busy)
    );

    alu_rr_scheduler #(.NUM_REQ(N), .ALU_LATENCY(3), .ID_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3),
        .alu_data_1(alu3_d1), .alu_data_2(alu3_d2), .alu_opcode(alu3_op),
        .alu_out(alu3_out), .busy(busy3)
    );

    // Behavioural ALU: shifts use data_2[2:0] as the shift amount
    function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_RST:  return 8'h00;
            OP_MOV:  return a;
            OP_NOT:  return ~a;
            OP_ADD:  return a + b;
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_LSH:  return a << b[2:0];
            default: return a >> b[2:0];
        endcase
    endfunction

    initial alu_out = 8'h00;
    always @(posedge clk) alu_out <= ref_alu(alu_op, alu_d1, alu_d2);
    always @(posedge clk) begin
        pipe3[0] <= ref_alu(alu3_op, alu3_d1, alu3_d2);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign alu3_out = pipe3[2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int j = (last + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    typedef struct packed { logic [1:0] id; logic [7:0] data; } rsp_t;
    rsp_t        exp_q[$];
    int          grant_log[$];
    int          model_last = N - 1;
    bit          model_busy = 1'b0;
    logic [N-1:0] hs_mask = '0;
    int          cyc = 0;
    int          accept_cyc = 0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    logic [1:0]  prev_id = '0;
    logic [7:0]  prev_data = '0;
    int          mw;
    logic [N-1:0] exp_ready;
    rsp_t        me;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            model_last = N - 1;
            model_busy = 1'b0;
            exp_q.delete();
            hs_mask    = '0;
            prev_valid = 1'b0;
        end else begin
            exp_ready = '0;
            mw = model_busy ? -1 : rr_pick(bus.req_valid, model_last);
            if (mw >= 0) exp_ready[mw] = 1'b1;
            if (bus.req_valid != '0 || bus.req_ready != '0)
                check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(model_busy));
            if (!model_busy) check("alu_opcode_idle", 32'(alu_op), 32'(OP_RST));
            if (bus.rsp_valid) begin
                if (!prev_valid) check("rsp_latency", 32'(cyc - accept_cyc), 32'd3);
                else if (!prev_ready) begin
                    check("rsp_hold_id", 32'(bus.rsp_id), 32'(prev_id));
                    check("rsp_hold_data", 32'(bus.rsp_data), 32'(prev_data));
                end
                if (bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rsp_unexpected: got id %0d data %0h, required no response", bus.rsp_id, bus.rsp_data);
                    end else begin
                        me = exp_q.pop_front();
                        check("rsp_id", 32'(bus.rsp_id), 32'(me.id));
                        check("rsp_data", 32'(bus.rsp_data), 32'(me.data));
                    end
                    model_busy = 1'b0;
                end
            end
            prev_valid = bus.rsp_valid;
            prev_ready = bus.rsp_ready;
            prev_id    = bus.rsp_id;
            prev_data  = bus.rsp_data;
            hs_mask    = exp_ready;
            if (mw >= 0) begin
                me.id   = 2'(mw);
                me.data = ref_alu(bus.req_opcode[3*mw +: 3], bus.req_a[8*mw +: 8], bus.req_b[8*mw +: 8]);
                exp_q.push_back(me);
                model_last = mw;
                model_busy = 1'b1;
                accept_cyc = cyc;
                grant_log.push_back(mw);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_opcode[3*i +: 3] = op;
        bus.req_a[8*i +: 8]      = a;
        bus.req_b[8*i +: 8]      = b;
        bus.req_valid[i]         = 1'b1;
    endtask

    // Advance one cycle; accepted requesters drop valid and scramble their fields
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_mask[i]) begin
                bus.req_valid[i]         = 1'b0;
                bus.req_opcode[3*i +: 3] = 3'($urandom);
                bus.req_a[8*i +: 8]      = 8'($urandom);
                bus.req_b[8*i +: 8]      = 8'($urandom);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((bus.req_valid != '0 || busy || bus.rsp_valid) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: still active after %0d cycles, required idle", name, k);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One operation on the ALU_LATENCY=3 instance with edge-accurate latency check
    task automatic run3(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_data);
        logic [N-1:0] oh;
        int n;
        oh = '0;
        oh[id] = 1'b1;
        bus3.req_opcode[3*id +: 3] = op;
        bus3.req_a[8*id +: 8]      = a;
        bus3.req_b[8*id +: 8]      = b;
        bus3.req_valid[id]         = 1'b1;
        #1;
        check("l3_req_ready", 32'(bus3.req_ready), 32'(oh));
        @(posedge clk);
        #1;
        bus3.req_valid       = '0;
        bus3.req_a[8*id +: 8] = 8'($urandom);
        n = 0;
        while (!bus3.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("l3_latency_edges", 32'(n), 32'd4);
        check("l3_rsp_id", 32'(bus3.rsp_id), 32'(id));
        check("l3_rsp_data", 32'(bus3.rsp_data), 32'(exp_data));
        @(posedge clk);
        #1;
        check("l3_busy_after", 32'(busy3), 32'd0);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    int exp_order [5] = '{0, 1, 2, 3, 0};
    bit re0;
    int k;

    initial begin
        bus.req_valid = '0;  bus.req_opcode = '0;  bus.req_a = '0;  bus.req_b = '0;  bus.rsp_ready = 1'b1;
        bus3.req_valid = '0; bus3.req_opcode = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.rsp_ready = 1'b1;
        rst_n = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_opcode", 32'(alu_op), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_req_ready", 32'(bus.req_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Single ADD from requester 2 (overflow truncated)
        set_req(2, OP_ADD, 8'hF0, 8'h20);
        #1;
        check("add_req_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        check("add_exec_opcode", 32'(alu_op), 32'(OP_ADD));
        check("add_exec_ready", 32'(bus.req_ready), 32'd0);
        tick();
        tick();
        check("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("add_rsp_id", 32'(bus.rsp_id), 32'd2);
        check("add_rsp_data", 32'(bus.rsp_data), 32'h10);
        wait_idle("add");

        // Round-robin fairness from a fresh pointer
        pulse_reset();
        grant_log.delete();
        set_req(0, OP_MOV, 8'h11, 8'h00);
        set_req(1, OP_NOT, 8'h0F, 8'h00);
        set_req(2, OP_XOR, 8'h55, 8'hFF);
        set_req(3, OP_LSH, 8'h3C, 8'h04);
        re0 = 1'b0;
        k = 0;
        while (grant_log.size() < 5 && k < 60) begin
            tick();
            k++;
            if (!re0 && grant_log.size() >= 1 && !bus.req_valid[0]) begin
                set_req(0, OP_ADD, 8'h7F, 8'h81);
                re0 = 1'b1;
            end
        end
        if (grant_log.size() < 5) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rr_grant_count: got %0d grants, required 5", grant_log.size());
        end else begin
            for (int i = 0; i < 5; i++) check("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));
        end
        wait_idle("rr");

        // Backpressure with other requests pending
        bus.rsp_ready = 1'b0;
        set_req(1, OP_RSH, 8'hA5, 8'h04);
        set_req(0, OP_MOV, 8'h5A, 8'h00);
        set_req(3, OP_AND, 8'hF3, 8'h3F);
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            tick();
            k++;
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.rsp_ready = 1'b1;
            #1;
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
            check("bp_rsp_data", 32'(bus.rsp_data), 32'h0A);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        wait_idle("bp");

        // Reset during WAIT: operation discarded, pointer restarts at requester 0
        set_req(2, OP_ADD, 8'h01, 8'h01);
        k = 0;
        while (bus.req_valid[2] && k < 20) begin
            tick();
            k++;
        end
        tick();
        check("mid_busy_before", 32'(busy), 32'd1);
        set_req(3, OP_XOR, 8'h0F, 8'hF0);
        set_req(0, OP_NOT, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_alu_opcode", 32'(alu_op), 32'd0);
        check("mid_alu_data_1", 32'(alu_d1), 32'd0);
        check("mid_req_ready", 32'(bus.req_ready), 32'd0);
        grant_log.delete();
        tick();
        tick();
        rst_n = 1'b1;
        k = 0;
        while (grant_log.size() < 2 && k < 40) begin
            tick();
            k++;
        end
        if (grant_log.size() < 2) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mid_grant_count: got %0d grants, required 2", grant_log.size());
        end else begin
            check("mid_first_grant", 32'(grant_log[0]), 32'd0);
            check("mid_second_grant", 32'(grant_log[1]), 32'd3);
        end
        wait_idle("mid");

        // Random traffic with withdrawals and response backpressure
        for (int t = 0; t < 400; t++) begin
            tick();
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                end else if ($urandom_range(0, 19) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        bus.rsp_ready = 1'b1;
        wait_idle("random");
        tick();
        tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        // Three-cycle ALU instance
        run3(0, OP_AND, 8'hCC, 8'h0F, 8'h0C);
        for (int t = 0; t < 6; t++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            int id;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            id = $urandom_range(0, N - 1);
            run3(id, op, a, b, ref_alu(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
